// File: rtl/relay_pulse_scheduler.sv
// Serializes latching-relay coil pulses: one coil energized at a time, a
// mandatory de-energized gap between pulses, a startup sweep to output mode,
// and per-relay state tracking so redundant requests cost no pulse.
module relay_pulse_scheduler #(
    parameter int NUM_RELAYS   = 4,
    parameter int PULSE_CYCLES = 625000,
    parameter int GAP_CYCLES   = 125000,
    parameter int CNT_W        = 20,
    localparam int IDX_W       = $clog2(NUM_RELAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [IDX_W-1:0]      req_index,
    input  logic                  req_dir,
    output logic                  req_ready,
    output logic [NUM_RELAYS-1:0] relay_a,
    output logic [NUM_RELAYS-1:0] relay_b,
    output logic [NUM_RELAYS-1:0] state_known,
    output logic [NUM_RELAYS-1:0] state_dir,
    output logic                  busy,
    output logic                  init_done
);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_RELAYS-1:0]   pending_q, pending_d;
    logic [NUM_RELAYS-1:0]   pdir_q, pdir_d;
    logic [IDX_W-1:0]        rr_q, rr_d;
    logic [IDX_W-1:0]        cur_idx_q, cur_idx_d;
    logic                    cur_dir_q, cur_dir_d;
    logic [NUM_RELAYS-1:0]   relay_a_q, relay_a_d;
    logic [NUM_RELAYS-1:0]   relay_b_q, relay_b_d;
    logic [NUM_RELAYS-1:0]   known_q, known_d;
    logic [NUM_RELAYS-1:0]   sdir_q, sdir_d;
    logic                    init_q, init_d;

    logic                    grant_vld;
    logic [IDX_W-1:0]        grant_idx;

    // Round-robin pick: first pending relay at or after rr_q (mod N).
    always_comb begin
        int j;
        grant_vld = 1'b0;
        grant_idx = '0;
        j = 0;
        for (int k = NUM_RELAYS - 1; k >= 0; k--) begin
            j = (int'(rr_q) + k) % NUM_RELAYS;
            if (pending_q[j]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    // State register; reset arms the sweep by marking every relay pending to output mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= '1;
            pdir_q    <= '1;
            rr_q      <= '0;
            cur_idx_q <= '0;
            cur_dir_q <= 1'b0;
            relay_a_q <= '0;
            relay_b_q <= '0;
            known_q   <= '0;
            sdir_q    <= '0;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            pdir_q    <= pdir_d;
            rr_q      <= rr_d;
            cur_idx_q <= cur_idx_d;
            cur_dir_q <= cur_dir_d;
            relay_a_q <= relay_a_d;
            relay_b_q <= relay_b_d;
            known_q   <= known_d;
            sdir_q    <= sdir_d;
            init_q    <= init_d;
        end
    end

    // Next-state: grant/skip in IDLE, timed coil drive in PULSE, timed rest in GAP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        pdir_d    = pdir_q;
        rr_d      = rr_q;
        cur_idx_d = cur_idx_q;
        cur_dir_d = cur_dir_q;
        relay_a_d = relay_a_q;
        relay_b_d = relay_b_q;
        known_d   = known_q;
        sdir_d    = sdir_q;
        init_d    = init_q;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    rr_d = IDX_W'((int'(grant_idx) + 1) % NUM_RELAYS);
                    pending_d[grant_idx] = 1'b0;
                    // A relay already known to be in the requested direction needs no pulse.
                    if (!(known_q[grant_idx] && (sdir_q[grant_idx] == pdir_q[grant_idx]))) begin
                        cur_idx_d = grant_idx;
                        cur_dir_d = pdir_q[grant_idx];
                        if (pdir_q[grant_idx]) relay_b_d[grant_idx] = 1'b1;
                        else                   relay_a_d[grant_idx] = 1'b1;
                        cnt_d   = CNT_W'(1);
                        state_d = PULSE;
                    end
                end else begin
                    init_d = 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == CNT_W'(PULSE_CYCLES)) begin
                    relay_a_d          = '0;
                    relay_b_d          = '0;
                    known_d[cur_idx_q] = 1'b1;
                    sdir_d[cur_idx_q]  = cur_dir_q;
                    cnt_d              = CNT_W'(1);
                    state_d            = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Applied last so a new request beats a same-cycle grant clear.
        if (req_valid && init_q) begin
            pending_d[req_index] = 1'b1;
            pdir_d[req_index]    = req_dir;
        end
    end

    assign req_ready   = init_q;
    assign relay_a     = relay_a_q;
    assign relay_b     = relay_b_q;
    assign state_known = known_q;
    assign state_dir   = sdir_q;
    assign busy        = (state_q != IDLE) || (|pending_q);
    assign init_done   = init_q;

    // Coil safety: at most one coil on, never both legs of a bridge, nothing outside PULSE.
    a_one_coil: assert property (@(posedge clk) disable iff (rst)
        $countones(relay_a_q | relay_b_q) <= 1);
    a_no_short: assert property (@(posedge clk) disable iff (rst)
        (relay_a_q & relay_b_q) == '0);
    a_off_idle: assert property (@(posedge clk) disable iff (rst)
        (state_q != PULSE) |-> ((relay_a_q | relay_b_q) == '0));

endmodule
